// File: rtl/shift_q_ctrl.sv
// Frame sequencer for the serial-to-parallel IQ shift register: gates its enable,
// splits a burst into L-bit frames with one flush shift each, and hands frames off via valid/ready.
module shift_q_ctrl #(
    parameter int SIZEIQ = 160,
    parameter int L      = 80,
    localparam int NF    = SIZEIQ / L,
    localparam int FIW   = $clog2(NF) + 1,
    localparam int BCW   = $clog2(L + 1)
) (
    input  logic           C,
    input  logic           RN,
    input  logic           START,
    input  logic           ABORT,
    input  logic           D,
    input  logic           DV,
    input  logic           FR,
    output logic           E,
    output logic           QO,
    output logic           FV,
    output logic [FIW-1:0] FIDX,
    output logic [BCW-1:0] BCNT,
    output logic           BUSY,
    output logic           DONE,
    output logic           OVR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FLUSH,
        S_HOLD
    } state_t;

    state_t         r_state;
    logic           r_e;
    logic           r_qo;
    logic           r_fv;
    logic [FIW-1:0] r_fidx;
    logic [BCW-1:0] r_bcnt;
    logic           r_busy;
    logic           r_done;
    logic           r_ovr;

    state_t         w_state_nx;
    logic           w_e_nx;
    logic           w_qo_nx;
    logic           w_fv_nx;
    logic [FIW-1:0] w_fidx_nx;
    logic [BCW-1:0] w_bcnt_nx;
    logic           w_done_nx;
    logic           w_ovr_nx;

    always_comb begin
        w_state_nx = r_state;
        w_e_nx     = 1'b0;
        w_qo_nx    = 1'b0;
        w_fv_nx    = r_fv;
        w_fidx_nx  = r_fidx;
        w_bcnt_nx  = r_bcnt;
        w_done_nx  = 1'b0;
        w_ovr_nx   = r_ovr;

        if (r_state == S_IDLE) begin
            if (START && !ABORT) begin
                w_state_nx = S_SHIFT;
                w_fidx_nx  = '0;
                w_bcnt_nx  = '0;
            end
        end else if (ABORT) begin
            w_state_nx = S_IDLE;
            w_fv_nx    = 1'b0;
            w_fidx_nx  = '0;
            w_bcnt_nx  = '0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (DV) begin
                        w_e_nx    = 1'b1;
                        w_qo_nx   = D;
                        w_bcnt_nx = r_bcnt + BCW'(1);
                        if (r_bcnt == BCW'(L - 1))
                            w_state_nx = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Extra zero shift moves the complete frame onto the lagging tap.
                    w_e_nx     = 1'b1;
                    w_state_nx = S_HOLD;
                    if (DV)
                        w_ovr_nx = 1'b1;
                end
                S_HOLD: begin
                    if (DV)
                        w_ovr_nx = 1'b1;
                    if (r_fv && FR) begin
                        w_fv_nx   = 1'b0;
                        w_bcnt_nx = '0;
                        if (r_fidx == FIW'(NF - 1)) begin
                            w_done_nx  = 1'b1;
                            w_fidx_nx  = '0;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_fidx_nx  = r_fidx + FIW'(1);
                            w_state_nx = S_SHIFT;
                        end
                    end else begin
                        w_fv_nx = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_e     <= 1'b0;
            r_qo    <= 1'b0;
            r_fv    <= 1'b0;
            r_fidx  <= '0;
            r_bcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_e     <= w_e_nx;
            r_qo    <= w_qo_nx;
            r_fv    <= w_fv_nx;
            r_fidx  <= w_fidx_nx;
            r_bcnt  <= w_bcnt_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_done_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    assign E    = r_e;
    assign QO   = r_qo;
    assign FV   = r_fv;
    assign FIDX = r_fidx;
    assign BCNT = r_bcnt;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign OVR  = r_ovr;

endmodule

// File: tb/tb_shift_q_ctrl.sv
// Bench for shift_q_ctrl: drives bursts through the sequencer and models the
// downstream falling-edge shift register to check the frames it delivers.
module tb_shift_q_ctrl;

    localparam int SIZEIQ = 160;
    localparam int L      = 80;
    localparam int NF     = SIZEIQ / L;
    localparam int FIW    = $clog2(NF) + 1;
    localparam int BCW    = $clog2(L + 1);

    logic           C = 1'b0;
    logic           RN = 1'b0;
    logic           START = 1'b0;
    logic           ABORT = 1'b0;
    logic           D = 1'b0;
    logic           DV = 1'b0;
    logic           FR = 1'b0;
    logic           E, QO, FV, BUSY, DONE, OVR;
    logic [FIW-1:0] FIDX;
    logic [BCW-1:0] BCNT;

    int n_pass = 0;
    int n_tot  = 0;

    logic [L-1:0] sr_model = '0;
    logic [L-1:0] n_model  = '0;

    shift_q_ctrl #(.SIZEIQ(SIZEIQ), .L(L)) dut (
        .C(C), .RN(RN), .START(START), .ABORT(ABORT), .D(D), .DV(DV), .FR(FR),
        .E(E), .QO(QO), .FV(FV), .FIDX(FIDX), .BCNT(BCNT),
        .BUSY(BUSY), .DONE(DONE), .OVR(OVR)
    );

    always #5 C = ~C;

    // Downstream shift register: samples on the falling edge; n lags sr by one shift.
    always @(negedge C) begin
        if (E === 1'b1) begin
            n_model  <= sr_model;
            sr_model <= {sr_model[L-2:0], QO};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge C);
        #1;
    endtask

    // Sends one frame from the SHIFT state; gap<0 means random gaps of 0..3 idle cycles.
    task automatic send_frame(input int f, input int gap, input bit alt, input logic fr_val);
        logic [L-1:0] exp_n;
        int           e_cnt;
        int           bad;
        int           g;
        logic         b;
        logic [FIW-1:0] exp_fidx;
        exp_n = '0;
        e_cnt = 0;
        bad   = 0;
        FR    = fr_val;
        for (int i = 0; i < L; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                DV = 1'b0;
                cyc();
                if (E !== 1'b0) bad++;
            end
            b = alt ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            exp_n[L-1-i] = b;
            DV = 1'b1;
            D  = b;
            cyc();
            DV = 1'b0;
            D  = 1'b0;
            if (E === 1'b1) e_cnt++;
            if (QO !== b || BCNT !== BCW'(i + 1) || FV !== 1'b0) bad++;
        end
        n_tot++;
        if (bad !== 0) $display("FAIL frame%0d_bits: %0d bad cycles, required 0", f, bad);
        else n_pass++;

        cyc();
        if (E === 1'b1) e_cnt++;
        n_tot++;
        if ({E, QO, FV} !== 3'b100)
            $display("FAIL frame%0d_flush: E,QO,FV=%b required 100", f, {E, QO, FV});
        else n_pass++;

        cyc();
        if (E === 1'b1) e_cnt++;
        n_tot++;
        if (FV !== 1'b1 || E !== 1'b0 || FIDX !== FIW'(f))
            $display("FAIL frame%0d_fv_rise: FV=%b E=%b FIDX=%0d required 1 0 %0d", f, FV, E, FIDX, f);
        else n_pass++;
        n_tot++;
        if (n_model !== exp_n)
            $display("FAIL frame%0d_n: n=%h required %h", f, n_model, exp_n);
        else n_pass++;

        if (fr_val) begin
            cyc();
            if (E === 1'b1) e_cnt++;
            exp_fidx = (f == NF - 1) ? '0 : FIW'(f + 1);
            n_tot++;
            if (FV !== 1'b0 || BCNT !== '0 || FIDX !== exp_fidx || DONE !== (f == NF - 1) ||
                BUSY !== (f != NF - 1) || OVR !== 1'b0)
                $display("FAIL frame%0d_accept: FV=%b BCNT=%0d FIDX=%0d DONE=%b BUSY=%b OVR=%b required 0 0 %0d %b %b 0",
                         f, FV, BCNT, FIDX, DONE, BUSY, OVR, exp_fidx, (f == NF - 1), (f != NF - 1));
            else n_pass++;
            n_tot++;
            if (e_cnt !== L + 1)
                $display("FAIL frame%0d_e_count: E high %0d edges, required %0d", f, e_cnt, L + 1);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        cyc();
        cyc();
        n_tot++;
        if ({E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR} !== '0)
            $display("FAIL reset_initial: outputs=%b required all 0", {E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR});
        else n_pass++;
        RN = 1'b1;
        START = 1'b1;
        cyc();
        START = 1'b0;
        for (int i = 0; i < 37; i++) begin
            DV = 1'b1;
            D  = 1'($urandom_range(0, 1));
            cyc();
        end
        DV = 1'b0;
        n_tot++;
        if (BCNT !== BCW'(37) || BUSY !== 1'b1)
            $display("FAIL reset_pre_bcnt: BCNT=%0d BUSY=%b required 37 1", BCNT, BUSY);
        else n_pass++;
        RN = 1'b0;
        DV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tot++;
            if ({E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR} !== '0)
                $display("FAIL reset_mid_shift%0d: outputs=%b required all 0", i, {E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR});
            else n_pass++;
        end
        RN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DV = 1'(i % 2);
            D  = 1'b1;
            cyc();
            n_tot++;
            if ({E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR} !== '0)
                $display("FAIL reset_release_idle%0d: outputs=%b required all 0", i, {E, QO, FV, FIDX, BCNT, BUSY, DONE, OVR});
            else n_pass++;
        end
        DV = 1'b0;
        D  = 1'b0;
    endtask

    task automatic run_burst(input int gap, input bit alt);
        START = 1'b1;
        cyc();
        START = 1'b0;
        n_tot++;
        if (BUSY !== 1'b1 || FIDX !== '0 || BCNT !== '0)
            $display("FAIL burst_start: BUSY=%b FIDX=%0d BCNT=%0d required 1 0 0", BUSY, FIDX, BCNT);
        else n_pass++;
        for (int f = 0; f < NF; f++)
            send_frame(f, gap, alt, 1'b1);
        FR = 1'b0;
        cyc();
        n_tot++;
        if (DONE !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL burst_done_pulse: DONE=%b BUSY=%b required 0 0", DONE, BUSY);
        else n_pass++;
    endtask

    task automatic test_nominal();
        run_burst(0, 1'b1);
    endtask

    task automatic test_gapped();
        run_burst(2, 1'b0);
    endtask

    task automatic test_random();
        run_burst(-1, 1'b0);
    endtask

    task automatic test_ignored();
        START = 1'b1;
        cyc();
        START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            DV = 1'b1;
            D  = 1'($urandom_range(0, 1));
            cyc();
        end
        DV = 1'b0;
        START = 1'b1;
        FR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tot++;
            if (BCNT !== BCW'(10) || FIDX !== '0 || BUSY !== 1'b1 || E !== 1'b0 || FV !== 1'b0)
                $display("FAIL ignored_in_shift%0d: BCNT=%0d FIDX=%0d BUSY=%b E=%b FV=%b required 10 0 1 0 0",
                         i, BCNT, FIDX, BUSY, E, FV);
            else n_pass++;
        end
        FR = 1'b0;
        ABORT = 1'b1;
        cyc();
        cyc();
        n_tot++;
        if (BUSY !== 1'b0)
            $display("FAIL start_abort_idle: BUSY=%b required 0", BUSY);
        else n_pass++;
        START = 1'b0;
        ABORT = 1'b0;
        cyc();
    endtask

    task automatic test_abort();
        int done_seen;
        START = 1'b1;
        cyc();
        START = 1'b0;
        send_frame(0, 0, 1'b0, 1'b1);
        FR = 1'b0;
        for (int i = 0; i < 40; i++) begin
            DV = 1'b1;
            D  = 1'($urandom_range(0, 1));
            cyc();
        end
        n_tot++;
        if (BCNT !== BCW'(40) || FIDX !== FIW'(1))
            $display("FAIL abort_pre: BCNT=%0d FIDX=%0d required 40 1", BCNT, FIDX);
        else n_pass++;
        ABORT = 1'b1;
        START = 1'b1;
        FR = 1'b1;
        D = 1'b1;
        cyc();
        ABORT = 1'b0;
        START = 1'b0;
        FR = 1'b0;
        DV = 1'b0;
        D = 1'b0;
        n_tot++;
        if ({E, QO, FV, FIDX, BCNT, BUSY, DONE} !== '0)
            $display("FAIL abort_state: E,QO,FV,FIDX,BCNT,BUSY,DONE=%b required all 0", {E, QO, FV, FIDX, BCNT, BUSY, DONE});
        else n_pass++;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (DONE !== 1'b0 || BUSY !== 1'b0) done_seen++;
        end
        n_tot++;
        if (done_seen !== 0)
            $display("FAIL abort_no_done: %0d cycles with DONE/BUSY high, required 0", done_seen);
        else n_pass++;
        START = 1'b1;
        cyc();
        START = 1'b0;
        n_tot++;
        if (BUSY !== 1'b1 || FIDX !== '0 || BCNT !== '0)
            $display("FAIL abort_restart: BUSY=%b FIDX=%0d BCNT=%0d required 1 0 0", BUSY, FIDX, BCNT);
        else n_pass++;
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [L-1:0] n_hold;
        int bad;
        START = 1'b1;
        cyc();
        START = 1'b0;
        send_frame(0, 0, 1'b0, 1'b0);
        n_hold = n_model;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            DV = ((c % 4) == 1) && (c < 20);
            D  = 1'b1;
            cyc();
            if (FV !== 1'b1 || E !== 1'b0 || n_model !== n_hold || BCNT !== BCW'(L) || FIDX !== '0) bad++;
            if (c >= 1 && OVR !== 1'b1) bad++;
        end
        DV = 1'b0;
        D = 1'b0;
        n_tot++;
        if (bad !== 0) $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad);
        else n_pass++;
        FR = 1'b1;
        cyc();
        FR = 1'b0;
        n_tot++;
        if (FV !== 1'b0 || FIDX !== FIW'(1) || BCNT !== '0 || BUSY !== 1'b1 || OVR !== 1'b1)
            $display("FAIL backpressure_accept: FV=%b FIDX=%0d BCNT=%0d BUSY=%b OVR=%b required 0 1 0 1 1",
                     FV, FIDX, BCNT, BUSY, OVR);
        else n_pass++;
        DV = 1'b1;
        D = 1'b1;
        cyc();
        DV = 1'b0;
        D = 1'b0;
        n_tot++;
        if (E !== 1'b1 || QO !== 1'b1 || BCNT !== BCW'(1))
            $display("FAIL backpressure_resume: E=%b QO=%b BCNT=%0d required 1 1 1", E, QO, BCNT);
        else n_pass++;
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        START = 1'b1;
        cyc();
        START = 1'b0;
        n_tot++;
        if (OVR !== 1'b1 || BUSY !== 1'b1)
            $display("FAIL ovr_sticky: OVR=%b BUSY=%b required 1 1", OVR, BUSY);
        else n_pass++;
        RN = 1'b0;
        cyc();
        RN = 1'b1;
        n_tot++;
        if (OVR !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL ovr_reset_clear: OVR=%b BUSY=%b required 0 0", OVR, BUSY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_random();
        test_ignored();
        test_abort();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
